if_row_tagger: RTL and testbench
================================

IF_ROW_TAGGER -- requirements
Module: if_row_tagger

Interface
REQ-001 Parameter IF_SCRATCH_WIDTH, default 16, is the pixel data width.
REQ-002 Parameter ROW_LEN_W, default 8, is the width of the row-length configuration field.
REQ-003 Parameter ROW_CNT_W, default 8, is the width of the row-count configuration field.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 start  in  1  one-cycle pulse that latches the configuration and begins a frame.
REQ-007 row_len  in  ROW_LEN_W  number of pixels per row; sampled on start.
REQ-008 num_rows  in  ROW_CNT_W  number of rows in the frame; sampled on start.
REQ-009 pix_valid  in  1  upstream pixel is valid.
REQ-010 pix_data  in  IF_SCRATCH_WIDTH  signed pixel value.
REQ-011 pix_ready  out  1  tagger accepts the pixel this cycle.
REQ-012 IF_full  in  1  full flag of the downstream IF buffer.
REQ-013 IF_wen  out  1  write enable into the IF buffer.
REQ-014 IF_din  out  IF_SCRATCH_WIDTH+2  tagged word {sor, eor, pixel}.
REQ-015 busy  out  1  a frame is in progress.
REQ-016 done  out  1  one-cycle pulse when the last word of the frame is written.
REQ-017 cfg_err  out  1  one-cycle pulse when start is rejected.

Function
REQ-018 The FSM SHALL have three states: IDLE, STREAM and DRAIN.
REQ-019 IDLE: start with row_len!=0 and num_rows!=0 latches both values, clears the column and row counters, and moves to STREAM; busy rises the next cycle.
REQ-020 IDLE: start with row_len==0 or num_rows==0 pulses cfg_err for one cycle and stays in IDLE.
REQ-021 start outside IDLE SHALL be ignored, with no cfg_err.
REQ-022 A handshake occurs when pix_valid && pix_ready; pix_ready = (state==STREAM) && (!out_vld || !IF_full).
REQ-023 Each accepted pixel SHALL load a single output register: sor = (col==0), eor = (col==row_len-1), data = pix_data unchanged. Latency is one cycle from handshake to IF_wen.
REQ-024 row_len==1 SHALL produce tag 2'b11 on every word.
REQ-025 IF_wen = out_vld && !IF_full; while IF_full=1 the output register and IF_din SHALL hold.
REQ-026 A write and a new handshake in the same cycle SHALL replace the output register with no bubble, giving one word per cycle at full throughput.
REQ-027 col wraps to 0 after row_len-1 and row then increments. Accepting the pixel that closes the last row SHALL move the FSM to DRAIN and drop pix_ready.
REQ-028 DRAIN: when the final word is written, done pulses in that same cycle, the FSM returns to IDLE and busy falls the next cycle.
REQ-029 IF_wen SHALL never be asserted while IF_full=1.
REQ-030 No pixel SHALL be dropped or duplicated under any pix_valid or IF_full pattern.

Reset
REQ-031 On rst all outputs SHALL go to 0 (IF_din = 0), out_vld, counters and latched configuration SHALL clear, and the FSM SHALL enter IDLE.
REQ-032 rst mid-frame SHALL abort the frame and discard the pending word; no done pulse is produced.

Structure
REQ-033 The tag encodings (SOR=2'b10, EOR=2'b01, SINGLE=2'b11, NONE=2'b00) and the FSM state encoding SHALL live in a shared package used by this block and the IF-buffer consumer.
REQ-034 The block SHALL be a single module with no sub-modules.

Verification
REQ-035 row_len=6, num_rows=2, pixels 14,39,164,171,-6,-80,122,9,155,-51,-26,147, no stalls -> 12 consecutive writes: 18'h2000E first, 18'h1FFB0 sixth, 18'h2007A seventh, 18'h10093 last; done pulses with the twelfth write.
REQ-036 Same stream with IF_full=1 for 5 cycles after the third write -> IF_din holds 18'h000AB and IF_wen=0 throughout the stall; output sequence otherwise identical.
REQ-037 row_len=1, num_rows=3, pixels 5,6,7 -> 18'h30005, 18'h30006, 18'h30007.
REQ-038 start with row_len=0 -> cfg_err pulses once, busy stays 0, no IF_wen.
REQ-039 rst asserted after 4 of 12 pixels -> IF_wen=0 and busy=0 immediately; a new start then yields a first word carrying sor=1.
REQ-040 Random pix_valid and IF_full (50% each) over 8 rows of 16 pixels -> scoreboard matches all 128 words and tags exactly.

Source files
------------

// File: rtl/if_row_tagger_pkg.sv
// Shared definitions for the row tagger and the IF-buffer consumer:
// tag encodings carried in the two MSBs of each IF word, plus the FSM state encoding.
package if_row_tagger_pkg;

    localparam int unsigned TAG_W = 2;

    typedef logic [TAG_W-1:0] tag_t;

    localparam tag_t TAG_NONE   = 2'b00;
    localparam tag_t TAG_EOR    = 2'b01;
    localparam tag_t TAG_SOR    = 2'b10;
    localparam tag_t TAG_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } tagger_state_e;

    // Tag is {sor, eor}; a one-pixel row therefore yields TAG_SINGLE.
    function automatic tag_t make_tag(input logic sor, input logic eor);
        return {sor, eor};
    endfunction

endpackage

// File: rtl/if_row_tagger.sv
// if_row_tagger: accepts a frame of signed pixels over a valid/ready handshake and
// writes each one into the IF buffer tagged with start-of-row / end-of-row flags.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           pulse: latch row_len/num_rows and begin a frame (IDLE only)
//   row_len         pixels per row, sampled on start
//   num_rows        rows per frame, sampled on start
//   pix_valid       upstream pixel valid
//   pix_data        signed pixel value
//   pix_ready       pixel accepted this cycle
//   IF_full         downstream buffer full
//   IF_wen          write enable into the IF buffer
//   IF_din          tagged word {sor, eor, pixel}
//   busy            frame in progress
//   done            pulse coincident with the frame's final write
//   cfg_err         pulse when a start is rejected for a zero dimension
module if_row_tagger
    import if_row_tagger_pkg::*;
#(
    parameter int unsigned IF_SCRATCH_WIDTH = 16,
    parameter int unsigned ROW_LEN_W        = 8,
    parameter int unsigned ROW_CNT_W        = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ROW_LEN_W-1:0]              row_len,
    input  logic [ROW_CNT_W-1:0]              num_rows,
    input  logic                              pix_valid,
    input  logic [IF_SCRATCH_WIDTH-1:0]       pix_data,
    output logic                              pix_ready,
    input  logic                              IF_full,
    output logic                              IF_wen,
    output logic [IF_SCRATCH_WIDTH+TAG_W-1:0] IF_din,
    output logic                              busy,
    output logic                              done,
    output logic                              cfg_err
);

    localparam int unsigned DOUT_W = IF_SCRATCH_WIDTH + TAG_W;

    tagger_state_e          state_q,    state_d;
    logic [ROW_LEN_W-1:0]   row_len_q,  row_len_d;
    logic [ROW_CNT_W-1:0]   num_rows_q, num_rows_d;
    logic [ROW_LEN_W-1:0]   col_q,      col_d;
    logic [ROW_CNT_W-1:0]   row_q,      row_d;
    logic                   out_vld_q,  out_vld_d;
    logic [DOUT_W-1:0]      out_word_q, out_word_d;
    logic                   cfg_err_q,  cfg_err_d;

    logic hs;
    logic wr;
    logic last_col;
    logic last_row;

    // Ready whenever the output register is empty or is being drained this cycle.
    assign pix_ready = (state_q == ST_STREAM) && (!out_vld_q || !IF_full);
    assign hs        = pix_valid && pix_ready;
    assign wr        = out_vld_q && !IF_full;
    assign last_col  = (col_q == (row_len_q - ROW_LEN_W'(1)));
    assign last_row  = (row_q == (num_rows_q - ROW_CNT_W'(1)));

    assign IF_wen  = wr;
    assign IF_din  = out_word_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DRAIN) && wr;
    assign cfg_err = cfg_err_q;

    // Next-state, counters and the single-entry output register.
    always_comb begin
        state_d    = state_q;
        row_len_d  = row_len_q;
        num_rows_d = num_rows_q;
        col_d      = col_q;
        row_d      = row_q;
        out_vld_d  = out_vld_q && !wr;
        out_word_d = out_word_q;
        cfg_err_d  = 1'b0;

        // A write and a new load in the same cycle replace the word with no bubble.
        if (hs) begin
            out_vld_d  = 1'b1;
            out_word_d = {make_tag(col_q == '0, last_col), pix_data};
            if (last_col) begin
                col_d = '0;
                row_d = row_q + ROW_CNT_W'(1);
            end else begin
                col_d = col_q + ROW_LEN_W'(1);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((row_len != '0) && (num_rows != '0)) begin
                        row_len_d  = row_len;
                        num_rows_d = num_rows;
                        col_d      = '0;
                        row_d      = '0;
                        state_d    = ST_STREAM;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (hs && last_col && last_row) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_len_q  <= '0;
            num_rows_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            out_vld_q  <= 1'b0;
            out_word_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_len_q  <= row_len_d;
            num_rows_q <= num_rows_d;
            col_q      <= col_d;
            row_q      <= row_d;
            out_vld_q  <= out_vld_d;
            out_word_q <= out_word_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_if_row_tagger.sv
// Self-checking bench for if_row_tagger: directed vector tables plus randomized
// frames checked against a frame-level reference model.
module tb_if_row_tagger;

    localparam int unsigned DW = 16;
    localparam int unsigned OW = DW + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    row_len;
    logic [7:0]    num_rows;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_ready;
    logic          IF_full;
    logic          IF_wen;
    logic [OW-1:0] IF_din;
    logic          busy;
    logic          done;
    logic          cfg_err;

    if_row_tagger #(
        .IF_SCRATCH_WIDTH(DW),
        .ROW_LEN_W       (8),
        .ROW_CNT_W       (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .row_len  (row_len),
        .num_rows (num_rows),
        .pix_valid(pix_valid),
        .pix_data (pix_data),
        .pix_ready(pix_ready),
        .IF_full  (IF_full),
        .IF_wen   (IF_wen),
        .IF_din   (IF_din),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] pix;
        logic [OW-1:0] exp;
    } vec_t;

    typedef struct packed {
        logic [7:0] rl;
        logic [7:0] nr;
    } cfg_vec_t;

    vec_t     v35 [12];
    vec_t     v37 [3];
    cfg_vec_t vcfg[3];

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] pix_q[$];
    logic [OW-1:0] got_q[$];
    int            wr_cyc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: word k of a frame is tagged by its column k mod row_len.
    function automatic logic [OW-1:0] exp_word(input int k, input int rl, input logic [DW-1:0] p);
        logic sor;
        logic eor;
        sor = ((k % rl) == 0);
        eor = ((k % rl) == (rl - 1));
        return {sor, eor, p};
    endfunction

    task automatic do_start(input logic [7:0] rl, input logic [7:0] nr, input bit ok);
        @(negedge clk);
        start    = 1'b1;
        row_len  = rl;
        num_rows = nr;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_busy", 32'(busy), 32'(ok));
        check("start_cfg_err", 32'(cfg_err), 32'(!ok));
    endtask

    // Drives one frame cycle by cycle and records every IF write.
    // valid_mode: 0 always valid, 1 random.  full_mode: 0 never, 1 random, 2 stall 5 after 3rd write.
    task automatic run_frame(input int total, input int valid_mode, input int full_mode,
                             input int stop_after, input logic [OW-1:0] hold_exp,
                             input bit inject_start);
        int idx = 0;
        int nwr = 0;
        int cyc = 0;
        int stall_rem = 0;
        bit fin = 0;
        bit exp_done;
        got_q.delete();
        wr_cyc_q.delete();
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = inject_start && (cyc == 2);
            if (start) row_len = 8'd0;
            case (full_mode)
                1:       IF_full = 1'($urandom_range(0, 1));
                2:       IF_full = (stall_rem > 0);
                default: IF_full = 1'b0;
            endcase
            pix_valid = (idx < total) && ((valid_mode == 0) || ($urandom_range(0, 1) == 1));
            pix_data  = (idx < total) ? pix_q[idx] : DW'($urandom);
            #1;
            if (inject_start && cyc == 3) check("start_ignored_cfg_err", 32'(cfg_err), 32'd0);
            if (full_mode == 2 && stall_rem > 0) begin
                check("stall_hold_din", 32'(IF_din), 32'(hold_exp));
                check("stall_no_wen", 32'(IF_wen), 32'd0);
                stall_rem--;
            end
            exp_done = IF_wen && (nwr == total - 1);
            check("done_pulse", 32'(done), 32'(exp_done));
            if (IF_wen) begin
                check("wen_while_full", 32'(IF_full), 32'd0);
                got_q.push_back(IF_din);
                wr_cyc_q.push_back(cyc);
                nwr++;
                if (full_mode == 2 && nwr == 3) stall_rem = 5;
                if (nwr == total) fin = 1;
            end
            if (pix_valid && pix_ready) begin
                idx++;
                if (stop_after >= 0 && idx == stop_after) fin = 1;
            end
        end
        if (!fin) check("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_frame();
        @(negedge clk);
        pix_valid = 1'b0;
        IF_full   = 1'b0;
        #1;
        check("busy_fall", 32'(busy), 32'd0);
    endtask

    task automatic check_vs_table35(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'd12);
        for (int i = 0; i < 12 && i < got_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(v35[i].exp));
    endtask

    task automatic check_vs_model(input string tag, input int rl, input int total);
        check({tag, "_count"}, 32'(got_q.size()), 32'(total));
        for (int i = 0; i < total && i < got_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_word(i, rl, pix_q[i])));
    endtask

    initial begin
        v35[0]  = '{16'h000E, 18'h2000E};
        v35[1]  = '{16'h0027, 18'h00027};
        v35[2]  = '{16'h00A4, 18'h000A4};
        v35[3]  = '{16'h00AB, 18'h000AB};
        v35[4]  = '{16'hFFFA, 18'h0FFFA};
        v35[5]  = '{16'hFFB0, 18'h1FFB0};
        v35[6]  = '{16'h007A, 18'h2007A};
        v35[7]  = '{16'h0009, 18'h00009};
        v35[8]  = '{16'h009B, 18'h0009B};
        v35[9]  = '{16'hFFCD, 18'h0FFCD};
        v35[10] = '{16'hFFE6, 18'h0FFE6};
        v35[11] = '{16'h0093, 18'h10093};
        v37[0]  = '{16'h0005, 18'h30005};
        v37[1]  = '{16'h0006, 18'h30006};
        v37[2]  = '{16'h0007, 18'h30007};
        vcfg[0] = '{8'd0, 8'd2};
        vcfg[1] = '{8'd3, 8'd0};
        vcfg[2] = '{8'd0, 8'd0};

        rst = 1'b1; start = 1'b0; row_len = '0; num_rows = '0;
        pix_valid = 1'b0; pix_data = '0; IF_full = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_wen", 32'(IF_wen), 32'd0);
        check("rst_din", 32'(IF_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_ready", 32'(pix_ready), 32'd0);
        rst = 1'b0;

        // Full-rate frame; a mid-frame start with row_len=0 must be ignored.
        pix_q.delete();
        foreach (v35[i]) pix_q.push_back(v35[i].pix);
        do_start(8'd6, 8'd2, 1'b1);
        run_frame(12, 0, 0, -1, '0, 1'b1);
        finish_frame();
        check_vs_table35("nostall");
        if (wr_cyc_q.size() == 12) check("back_to_back", 32'(wr_cyc_q[11] - wr_cyc_q[0]), 32'd11);

        // Same stream with a 5-cycle downstream stall after the third write.
        do_start(8'd6, 8'd2, 1'b1);
        run_frame(12, 0, 2, -1, 18'h000AB, 1'b0);
        finish_frame();
        check_vs_table35("stall");

        // One-pixel rows carry both tags.
        pix_q.delete();
        foreach (v37[i]) pix_q.push_back(v37[i].pix);
        do_start(8'd1, 8'd3, 1'b1);
        run_frame(3, 0, 0, -1, '0, 1'b0);
        finish_frame();
        check("single_count", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < got_q.size(); i++)
            check($sformatf("single_word%0d", i), 32'(got_q[i]), 32'(v37[i].exp));

        // Rejected configurations.
        foreach (vcfg[i]) begin
            do_start(vcfg[i].rl, vcfg[i].nr, 1'b0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                #1;
                check("cfg_err_single_pulse", 32'(cfg_err), 32'd0);
                check("cfg_no_wen", 32'(IF_wen), 32'd0);
                check("cfg_no_busy", 32'(busy), 32'd0);
            end
        end

        // Reset after four accepted pixels aborts the frame.
        pix_q.delete();
        for (int i = 0; i < 12; i++) pix_q.push_back(DW'($urandom));
        do_start(8'd6, 8'd2, 1'b1);
        run_frame(12, 0, 0, 4, '0, 1'b0);
        @(negedge clk);
        pix_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_wen", 32'(IF_wen), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_din", 32'(IF_din), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pix_q.delete();
        for (int i = 0; i < 6; i++) pix_q.push_back(DW'($urandom));
        do_start(8'd3, 8'd2, 1'b1);
        run_frame(6, 0, 0, -1, '0, 1'b0);
        finish_frame();
        if (got_q.size() > 0) check("post_abort_sor", 32'(got_q[0][OW-1]), 32'd1);
        check_vs_model("post_abort", 3, 6);

        // Random valid/full over 8 rows of 16 pixels.
        pix_q.delete();
        for (int i = 0; i < 128; i++) pix_q.push_back(DW'($urandom));
        do_start(8'd16, 8'd8, 1'b1);
        run_frame(128, 1, 1, -1, '0, 1'b0);
        finish_frame();
        check_vs_model("rand16x8", 16, 128);

        // A few random small geometries.
        for (int f = 0; f < 3; f++) begin
            int rl;
            int nr;
            rl = int'($urandom_range(1, 7));
            nr = int'($urandom_range(1, 4));
            pix_q.delete();
            for (int i = 0; i < rl * nr; i++) pix_q.push_back(DW'($urandom));
            do_start(8'(rl), 8'(nr), 1'b1);
            run_frame(rl * nr, 1, 1, -1, '0, 1'b0);
            finish_frame();
            check_vs_model($sformatf("rand_geom%0d", f), rl, rl * nr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
